picomips_run_ctrl: RTL and testbench
====================================

Name: picomips_run_ctrl

Overview:
- Run sequencer between the board switches/LEDs and the picoMIPS CPU core.
- Synchronises and debounces the enable switch, latches the 8-bit index, and gates the CPU with a slow clock-enable derived from fastclk.
- Performs an input valid/ready handshake and an output valid capture with the CPU, then holds the result on the LEDs until the enable switch is released.

Parameters:
- DATA_W, 8: width of the index, CPU data and LED bus.
- DIV_W, 12: prescaler width; one tick every 2^DIV_W fastclk cycles.
- DEB_TICKS, 4: consecutive equal tick-samples required to accept a new enable level.
- TIMEOUT_TICKS, 256: watchdog limit in ticks (used only with RUN_TIMEOUT_EN).

Ports:
- fastclk, in, 1: sole clock, rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- sw_en, in, 1: raw enable switch (SW[8]), asynchronous.
- sw_data, in, DATA_W: raw index switches (SW[7:0]), asynchronous.
- cpu_ce, out, 1: one-fastclk-cycle CPU clock-enable pulse.
- cpu_run, out, 1: high while the CPU is being sequenced (LOAD, RUN).
- cpu_in_data, out, DATA_W: latched index presented to the CPU.
- cpu_in_valid, out, 1: index valid.
- cpu_in_ready, in, 1: CPU accepts index; sampled only when cpu_ce=1.
- cpu_out_valid, in, 1: CPU result valid; sampled only when cpu_ce=1.
- cpu_out_data, in, DATA_W: CPU result.
- led, out, DATA_W: displayed result (registered).
- busy, out, 1: state is not IDLE.
- err, out, 1: watchdog fired (RUN_TIMEOUT_EN only, else constant 0).

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: state=IDLE, led=0, cpu_ce=0, cpu_run=0, cpu_in_valid=0, cpu_in_data=0, busy=0, err=0.
  - Internal: prescaler=0, debounce counter=0, stable enable=0.
  - Asserting reset mid-run aborts immediately; no partial result reaches led.
- Synchronisers: 2-flop synchroniser on sw_en and on each sw_data bit.
- Prescaler:
  - DIV_W-bit free-running up-counter; tick=1 when the counter is all-ones, wrapping to 0 next cycle.
- Debounce:
  - On each tick, compare the synced sw_en with en_stable. If different, increment the counter; otherwise clear it.
  - When the counter reaches DEB_TICKS, en_stable flips and the counter clears.
  - en_rise/en_fall are single-cycle pulses on each flip.
- cpu_ce = tick AND state in {LOAD, RUN}. cpu_run = state in {LOAD, RUN}.
- FSM transitions:
  - IDLE: on en_rise, capture synced sw_data into cpu_in_data, go to LOAD.
  - LOAD: cpu_in_valid=1. On a cycle with cpu_ce=1 and cpu_in_ready=1, drop valid and go to RUN.
  - RUN: on a cycle with cpu_ce=1 and cpu_out_valid=1, set led<=cpu_out_data and go to DONE.
  - DONE: cpu_ce held 0; led is held. On en_fall, go to IDLE (led keeps its value).
- Boundary conditions:
  - en_fall during LOAD/RUN is ignored; the run completes and DONE waits for the enable to be low.
  - If the enable is already low on entry to DONE, DONE waits for the next en_fall only if en_stable=1; otherwise it returns to IDLE the next cycle.
  - sw_data changes after capture have no effect.
  - In LOAD, cpu_out_valid is ignored.
  - In RUN, cpu_in_ready is ignored.
  - Handshake latency: LOAD to RUN within one tick of cpu_in_ready being asserted.
  - en_rise while in DONE cannot occur (enable stays high there).

Optional Feature:
- RUN_TIMEOUT_EN defined:
  - A tick counter clears on entry to LOAD and increments on each tick in LOAD/RUN.
  - On reaching TIMEOUT_TICKS: led<=all-ones, err<=1, go to DONE.
  - err clears on the next en_rise or on reset.
- RUN_TIMEOUT_EN not defined: no counter; err tied to 0; LOAD/RUN wait indefinitely.

Decomposition:
- Package picomips_ctrl_pkg: state enum (IDLE, LOAD, RUN, DONE, 2-bit); default DATA_W, DIV_W, DEB_TICKS; LED_TIMEOUT_CODE constant (all-ones).
- Sub-module sw_debounce: 2-flop synchroniser plus tick-sampled debounce counter; outputs en_stable, en_rise, en_fall.
- Prescaler and FSM stay in the top module.

Test Plan (DIV_W=4, DEB_TICKS=2, CPU model replies after 3 ce pulses):
- Reset, then sw_data=2 and sw_en=1 -> after 2 debounce ticks, busy=1, cpu_in_data=2, cpu_in_valid=1; cpu_ce pulses every 16 cycles.
- Model asserts ready, then out_valid with data 0x1C -> led=0x1C, state DONE, cpu_ce stays 0 while sw_en stays high.
- sw_en glitch high for 1 tick only -> no state change, led unchanged.
- sw_data changed 80->128 during RUN -> result computed from 80; next run after the enable is released and re-asserted uses 128.
- rst_n low mid-RUN -> led=0, busy=0, cpu_ce=0 asynchronously; a clean rerun with i=254 completes.
- With RUN_TIMEOUT_EN and TIMEOUT_TICKS=8, the model never responds -> after 8 ticks led=0xFF, err=1; next en_rise clears err.

Source files
------------

// File: rtl/picomips_ctrl_pkg.sv
// Shared types and defaults for the picoMIPS run sequencer.
// Optional build macro: RUN_TIMEOUT_EN (adds the LOAD/RUN watchdog).
package picomips_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int DEF_DATA_W        = 8;
    localparam int DEF_DIV_W         = 12;
    localparam int DEF_DEB_TICKS     = 4;
    localparam int DEF_TIMEOUT_TICKS = 256;

    // Pattern shown on the LEDs when the watchdog aborts a run.
    localparam logic [DEF_DATA_W-1:0] LED_TIMEOUT_CODE = '1;

endpackage

// File: rtl/picomips_run_ctrl_sw_debounce.sv
// Switch front end: 2-flop synchronisers on the enable and index switches,
// plus a tick-sampled debouncer producing a stable enable and edge pulses.
module sw_debounce
    import picomips_ctrl_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEB_TICKS = DEF_DEB_TICKS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick_i,
    input  logic              sw_en_i,
    input  logic [DATA_W-1:0] sw_data_i,
    output logic [DATA_W-1:0] data_sync_o,
    output logic              en_stable_o,
    output logic              en_rise_o,
    output logic              en_fall_o
);

    localparam int CNT_W = $clog2(DEB_TICKS + 1);

    logic [1:0]        en_sync_q;
    logic [DATA_W-1:0] data_meta_q;
    logic [DATA_W-1:0] data_sync_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              en_stable_q;
    logic              rise_q;
    logic              fall_q;

    // Two-stage synchronisers for the asynchronous switch inputs.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_sync_q   <= '0;
            data_meta_q <= '0;
            data_sync_q <= '0;
        end else begin
            en_sync_q   <= {en_sync_q[0], sw_en_i};
            data_meta_q <= sw_data_i;
            data_sync_q <= data_meta_q;
        end
    end

    // Accept a new enable level after DEB_TICKS consecutive differing tick samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            en_stable_q <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (tick_i) begin
                if (en_sync_q[1] != en_stable_q) begin
                    if (cnt_q == CNT_W'(DEB_TICKS - 1)) begin
                        en_stable_q <= en_sync_q[1];
                        cnt_q       <= '0;
                        rise_q      <= en_sync_q[1];
                        fall_q      <= ~en_sync_q[1];
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end else begin
                    cnt_q <= '0;
                end
            end
        end
    end

    assign data_sync_o = data_sync_q;
    assign en_stable_o = en_stable_q;
    assign en_rise_o   = rise_q;
    assign en_fall_o   = fall_q;

endmodule

// File: rtl/picomips_run_ctrl.sv
// Run sequencer between board switches/LEDs and the picoMIPS core: debounced
// enable, latched index, slow CPU clock-enable, input/output handshakes and
// LED hold until the enable is released.
// Optional build macro: RUN_TIMEOUT_EN (watchdog; sets err and shows
// LED_TIMEOUT_CODE if LOAD/RUN last TIMEOUT_TICKS ticks).
module picomips_run_ctrl
    import picomips_ctrl_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DIV_W     = DEF_DIV_W,
    parameter int DEB_TICKS = DEF_DEB_TICKS
`ifdef RUN_TIMEOUT_EN
    ,
    parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
`endif
) (
    input  logic              fastclk,
    input  logic              rst_n,
    input  logic              sw_en,
    input  logic [DATA_W-1:0] sw_data,
    output logic              cpu_ce,
    output logic              cpu_run,
    output logic [DATA_W-1:0] cpu_in_data,
    output logic              cpu_in_valid,
    input  logic              cpu_in_ready,
    input  logic              cpu_out_valid,
    input  logic [DATA_W-1:0] cpu_out_data,
    output logic [DATA_W-1:0] led,
    output logic              busy,
    output logic              err
);

    logic [DIV_W-1:0]  div_q;
    logic              tick;
    logic [DATA_W-1:0] data_sync;
    logic              en_stable;
    logic              en_rise;
    logic              en_fall;
    state_e            state_q;
    logic [DATA_W-1:0] in_data_q;
    logic [DATA_W-1:0] led_q;

    // Free-running prescaler; tick marks the all-ones count.
    always_ff @(posedge fastclk or negedge rst_n) begin
        if (!rst_n) div_q <= '0;
        else        div_q <= div_q + 1'b1;
    end

    assign tick = &div_q;

    sw_debounce #(
        .DATA_W    (DATA_W),
        .DEB_TICKS (DEB_TICKS)
    ) u_sw_debounce (
        .clk         (fastclk),
        .rst_n       (rst_n),
        .tick_i      (tick),
        .sw_en_i     (sw_en),
        .sw_data_i   (sw_data),
        .data_sync_o (data_sync),
        .en_stable_o (en_stable),
        .en_rise_o   (en_rise),
        .en_fall_o   (en_fall)
    );

    assign cpu_run = (state_q == LOAD) || (state_q == RUN);
    assign cpu_ce  = tick && cpu_run;

`ifdef RUN_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);
    logic [TO_W-1:0] to_cnt_q;
    logic            err_q;
`endif

    // Sequencer FSM with registered index, LED and error outputs.
    always_ff @(posedge fastclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            in_data_q <= '0;
            led_q     <= '0;
`ifdef RUN_TIMEOUT_EN
            to_cnt_q  <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: if (en_rise) begin
                    in_data_q <= data_sync;
                    state_q   <= LOAD;
`ifdef RUN_TIMEOUT_EN
                    to_cnt_q  <= '0;
`endif
                end
                LOAD: if (cpu_ce && cpu_in_ready) state_q <= RUN;
                RUN: if (cpu_ce && cpu_out_valid) begin
                    led_q   <= cpu_out_data;
                    state_q <= DONE;
                end
                // Leave as soon as the debounced enable is low, whether it
                // fell during the run or falls while we wait here.
                DONE: if (en_fall || !en_stable) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
`ifdef RUN_TIMEOUT_EN
            if (en_rise) err_q <= 1'b0;
            // cpu_ce is exactly "a tick while in LOAD/RUN"; a real result on
            // the final tick still wins over the watchdog.
            if (cpu_ce) begin
                to_cnt_q <= to_cnt_q + 1'b1;
                if (to_cnt_q == TO_W'(TIMEOUT_TICKS - 1) &&
                    !(state_q == RUN && cpu_out_valid)) begin
                    led_q   <= DATA_W'(LED_TIMEOUT_CODE);
                    err_q   <= 1'b1;
                    state_q <= DONE;
                end
            end
`endif
        end
    end

    assign cpu_in_valid = (state_q == LOAD);
    assign cpu_in_data  = in_data_q;
    assign led          = led_q;
    assign busy         = (state_q != IDLE);
`ifdef RUN_TIMEOUT_EN
    assign err          = err_q;
`else
    assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_picomips_run_ctrl.sv
// Directed bench for picomips_run_ctrl (DIV_W=4, DEB_TICKS=2). A small CPU
// model accepts the index on its 3rd ce pulse and returns index+26 on the 3rd
// ce pulse of RUN. Define RUN_TIMEOUT_EN to also exercise the watchdog.
module tb_picomips_run_ctrl;

    localparam int DATA_W = 8;

    logic              fastclk = 1'b0;
    logic              rst_n;
    logic              sw_en;
    logic [DATA_W-1:0] sw_data;
    logic              cpu_ce;
    logic              cpu_run;
    logic [DATA_W-1:0] cpu_in_data;
    logic              cpu_in_valid;
    logic              cpu_in_ready;
    logic              cpu_out_valid;
    logic [DATA_W-1:0] cpu_out_data;
    logic [DATA_W-1:0] led;
    logic              busy;
    logic              err;

    int n_checks = 0;
    int n_fail   = 0;

    picomips_run_ctrl #(
        .DATA_W    (DATA_W),
        .DIV_W     (4),
        .DEB_TICKS (2)
`ifdef RUN_TIMEOUT_EN
        ,
        .TIMEOUT_TICKS (8)
`endif
    ) dut (
        .fastclk       (fastclk),
        .rst_n         (rst_n),
        .sw_en         (sw_en),
        .sw_data       (sw_data),
        .cpu_ce        (cpu_ce),
        .cpu_run       (cpu_run),
        .cpu_in_data   (cpu_in_data),
        .cpu_in_valid  (cpu_in_valid),
        .cpu_in_ready  (cpu_in_ready),
        .cpu_out_valid (cpu_out_valid),
        .cpu_out_data  (cpu_out_data),
        .led           (led),
        .busy          (busy),
        .err           (err)
    );

    always #5 fastclk = ~fastclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // CPU model, updated on the falling edge so the DUT sees settled inputs.
    // In LOAD it also raises a bogus out_valid, and in RUN a bogus ready,
    // both of which the sequencer must ignore.
    bit              model_en = 1'b0;
    int              load_cnt;
    int              run_cnt;
    logic [DATA_W-1:0] result;

    always @(negedge fastclk) begin
        if (!model_en || !cpu_run) begin
            load_cnt      = 0;
            run_cnt       = 0;
            cpu_in_ready  = 1'b0;
            cpu_out_valid = 1'b0;
            cpu_out_data  = '0;
        end else if (cpu_in_valid) begin
            if (cpu_ce) load_cnt++;
            run_cnt       = 0;
            cpu_in_ready  = (load_cnt >= 3);
            cpu_out_valid = 1'b1;
            cpu_out_data  = 8'hEE;
            if (cpu_in_ready) result = cpu_in_data + 8'd26;
        end else begin
            if (cpu_ce) run_cnt++;
            cpu_in_ready  = 1'b1;
            cpu_out_valid = (run_cnt >= 3);
            cpu_out_data  = cpu_out_valid ? result : 8'h00;
        end
    end

    // 0: busy, 1: idle, 2: RUN, 3: DONE, 4: cpu_ce pulse
    function automatic bit cond(input int what);
        case (what)
            0:       return busy;
            1:       return !busy;
            2:       return cpu_run && !cpu_in_valid;
            3:       return busy && !cpu_run;
            default: return cpu_ce;
        endcase
    endfunction

    task automatic wait_for(input int what, input int budget, input string tag);
        int n = 0;
        bit met = cond(what);
        while (!met && n < budget) begin
            @(negedge fastclk);
            n++;
            met = cond(what);
        end
        check(tag, 32'(met), 32'd1);
    endtask

    initial begin
        int n;
        int ce_seen;

        rst_n   = 1'b0;
        sw_en   = 1'b0;
        sw_data = '0;
        repeat (3) @(negedge fastclk);
        check("rst_led",   32'(led), 32'h0);
        check("rst_busy",  32'(busy), 32'h0);
        check("rst_ce",    32'(cpu_ce), 32'h0);
        check("rst_run",   32'(cpu_run), 32'h0);
        check("rst_valid", 32'(cpu_in_valid), 32'h0);
        check("rst_idata", 32'(cpu_in_data), 32'h0);
        check("rst_err",   32'(err), 32'h0);
        rst_n    = 1'b1;
        model_en = 1'b1;

        // Run 1: index 2, result 0x1C.
        sw_data = 8'd2;
        sw_en   = 1'b1;
        wait_for(0, 100, "r1_start");
        check("r1_idata", 32'(cpu_in_data), 32'd2);
        check("r1_valid", 32'(cpu_in_valid), 32'd1);
        wait_for(4, 40, "r1_first_ce");
        n = 0;
        do begin
            @(negedge fastclk);
            n++;
        end while (!cpu_ce && n < 40);
        check("ce_period", 32'(n), 32'd16);
        check("r1_still_load", 32'(cpu_in_valid), 32'd1);
        wait_for(3, 200, "r1_done");
        check("r1_led", 32'(led), 32'h1C);
        ce_seen = 0;
        repeat (64) begin
            @(negedge fastclk);
            if (cpu_ce) ce_seen++;
        end
        check("done_no_ce", 32'(ce_seen), 32'd0);
        check("done_hold", 32'(busy), 32'd1);
        sw_en = 1'b0;
        wait_for(1, 100, "r1_idle");
        check("idle_led_kept", 32'(led), 32'h1C);

        // Enable glitch seen by exactly one tick: debouncer must reject it.
        sw_en = 1'b1;
        repeat (16) @(negedge fastclk);
        sw_en = 1'b0;
        repeat (64) @(negedge fastclk);
        check("glitch_busy", 32'(busy), 32'd0);
        check("glitch_led",  32'(led), 32'h1C);

        // Run 2: index 80, switches move to 128 mid-run; result 80+26=0x6A.
        sw_data = 8'd80;
        sw_en   = 1'b1;
        wait_for(2, 200, "r2_run");
        sw_data = 8'd128;
        wait_for(3, 200, "r2_done");
        check("r2_led",   32'(led), 32'h6A);
        check("r2_idata", 32'(cpu_in_data), 32'd80);
        sw_en = 1'b0;
        wait_for(1, 100, "r2_idle");

        // Run 3: index 128; enable dropped during LOAD, run still completes
        // and DONE returns straight to IDLE. Result 128+26=0x9A.
        sw_en = 1'b1;
        wait_for(0, 100, "r3_start");
        check("r3_idata", 32'(cpu_in_data), 32'd128);
        sw_en = 1'b0;
        wait_for(1, 300, "r3_idle");
        check("r3_led", 32'(led), 32'h9A);

        // Reset in RUN aborts at once; index 254 then reruns (254+26 = 0x18).
        sw_data = 8'd254;
        sw_en   = 1'b1;
        wait_for(2, 200, "r4_run");
        rst_n = 1'b0;
        #1;
        check("abort_led",  32'(led), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_ce",   32'(cpu_ce), 32'h0);
        check("abort_run",  32'(cpu_run), 32'h0);
        repeat (3) @(negedge fastclk);
        rst_n = 1'b1;
        wait_for(3, 300, "r5_done");
        check("r5_led",   32'(led), 32'h18);
        check("r5_idata", 32'(cpu_in_data), 32'd254);
        sw_en = 1'b0;
        wait_for(1, 100, "r5_idle");

`ifdef RUN_TIMEOUT_EN
        // Silent CPU: watchdog fires after 8 ticks.
        model_en = 1'b0;
        sw_en    = 1'b1;
        wait_for(0, 100, "to_start");
        wait_for(3, 300, "to_done");
        check("to_led", 32'(led), 32'hFF);
        check("to_err", 32'(err), 32'd1);
        sw_en = 1'b0;
        wait_for(1, 100, "to_idle");
        check("to_err_held", 32'(err), 32'd1);
        sw_en = 1'b1;
        wait_for(0, 100, "to_restart");
        check("to_err_clear", 32'(err), 32'd0);
        sw_en = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
